// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// program_loader : framed byte-stream boot loader into IMEM; holds the core in
//                  reset until the frame loads and its checksum matches.
// Revision 1.0
// ============================================================================
module program_loader #(
  parameter int IMEM_WORDS = 64,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_RUN   = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [7:0] C_MAX_N = 8'(IMEM_WORDS);

  state_t      state_q;
  logic [7:0]  count_q;
  logic [7:0]  word_idx_q;
  logic [7:0]  sum_q;
  logic [1:0]  byte_idx_q;
  logic [23:0] wbuf_q;

  logic        w_accept;
  logic [7:0]  sum_d;

  assign in_ready = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_CHECK);
  assign w_accept = in_valid && in_ready;
  assign sum_d    = sum_q + in_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= 8'd0;
      word_idx_q <= 8'd0;
      sum_q      <= 8'd0;
      byte_idx_q <= 2'd0;
      wbuf_q     <= 24'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      core_reset <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            if ((in_data == 8'd0) || (in_data > C_MAX_N)) begin
              state_q <= S_ERROR;
              error   <= 1'b1;
            end else begin
              count_q    <= in_data;
              word_idx_q <= 8'd0;
              byte_idx_q <= 2'd0;
              sum_q      <= 8'd0;
              state_q    <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            sum_q <= sum_d;
            if (byte_idx_q == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= ADDR_W'({word_idx_q, 2'b00});
              imem_wdata <= {in_data, wbuf_q};
              word_idx_q <= word_idx_q + 8'd1;
              byte_idx_q <= 2'd0;
              if (word_idx_q == count_q - 8'd1) begin
                state_q <= S_CHECK;
              end
            end else begin
              // Shift register: after three bytes wbuf_q holds {b2, b1, b0}.
              wbuf_q     <= {in_data, wbuf_q[23:8]};
              byte_idx_q <= byte_idx_q + 2'd1;
            end
          end
        end
        S_CHECK: begin
          if (w_accept) begin
            if (in_data == sum_q) begin
              state_q    <= S_RUN;
              core_reset <= 1'b0;
              done       <= 1'b1;
            end else begin
              state_q <= S_ERROR;
              error   <= 1'b1;
            end
          end
        end
        S_RUN, S_ERROR: begin
          if (start) begin
            state_q    <= S_IDLE;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          core_reset <= 1'b1;
          done       <= 1'b0;
          error      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
